// File: rtl/imem_loader.sv
// ============================================================================
// Module      : imem_loader
// Description : Packs an incoming byte stream little-endian into 32-bit words
//               and writes them to imem at consecutive word addresses, holding
//               the core in reset while a load is in progress.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader #(
    parameter int ADDR_W    = 13,
    parameter int MEM_DEPTH = 8192
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ADDR_W:0]   len_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_data_i,
    output logic              byte_ready_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [31:0]       wr_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [ADDR_W:0]   word_cnt_o,
    output logic [31:0]       checksum_o,
    output logic              core_rst_no
);

    localparam logic [ADDR_W:0] c_mem_depth = (ADDR_W+1)'(MEM_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W:0]   r_len;
    logic [1:0]        r_byte_cnt;
    logic [23:0]       r_word;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [31:0]       r_wr_data;
    logic [ADDR_W:0]   r_word_cnt;
    logic [31:0]       r_checksum;
    logic              r_error;

    logic              w_start_ok;
    logic              w_accept;
    logic              w_len_bad;
    logic              w_len_zero;
    logic [ADDR_W:0]   w_cnt_inc;

    // start_i only takes effect when no load is running
    assign w_start_ok = start_i && (r_state == S_IDLE || r_state == S_DONE);
    assign w_accept   = byte_valid_i && (r_state == S_RECV);
    assign w_len_bad  = (len_i > c_mem_depth);
    assign w_len_zero = (len_i == '0);
    assign w_cnt_inc  = r_word_cnt + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    w_state_nxt = (w_len_zero || w_len_bad) ? S_DONE : S_RECV;
                end
            end
            S_RECV: begin
                if (w_accept && r_byte_cnt == 2'd3) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                w_state_nxt = (w_cnt_inc == r_len) ? S_DONE : S_RECV;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_len      <= '0;
            r_byte_cnt <= '0;
            r_word     <= '0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_word_cnt <= '0;
            r_checksum <= '0;
            r_error    <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_len      <= len_i;
                r_byte_cnt <= '0;
                r_word_cnt <= '0;
                r_checksum <= '0;
                r_error    <= w_len_bad;
            end
            if (w_accept) begin
                r_byte_cnt <= r_byte_cnt + 1'b1;
                case (r_byte_cnt)
                    2'd0: r_word[7:0]   <= byte_data_i;
                    2'd1: r_word[15:8]  <= byte_data_i;
                    2'd2: r_word[23:16] <= byte_data_i;
                    default: begin
                        // Capture the full word here so the write port holds it after WRITE
                        r_wr_data <= {byte_data_i, r_word};
                        r_wr_addr <= r_word_cnt[ADDR_W-1:0];
                    end
                endcase
            end
            if (r_state == S_WRITE) begin
                r_word_cnt <= w_cnt_inc;
                r_checksum <= r_checksum ^ r_wr_data;
            end
        end
    end

    assign byte_ready_o = (r_state == S_RECV);
    assign wr_en_o      = (r_state == S_WRITE);
    assign wr_addr_o    = r_wr_addr;
    assign wr_data_o    = r_wr_data;
    assign busy_o       = (r_state == S_RECV) || (r_state == S_WRITE);
    assign done_o       = (r_state == S_DONE);
    assign error_o      = r_error;
    assign word_cnt_o   = r_word_cnt;
    assign checksum_o   = r_checksum;
    assign core_rst_no  = rst_ni & ~busy_o;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module      : tb_imem_loader
// Description : Directed self-checking bench for imem_loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

    localparam int ADDR_W    = 13;
    localparam int MEM_DEPTH = 8192;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              start_i = 1'b0;
    logic [ADDR_W:0]   len_i = '0;
    logic              byte_valid_i = 1'b0;
    logic [7:0]        byte_data_i = '0;
    logic              byte_ready_o;
    logic              wr_en_o;
    logic [ADDR_W-1:0] wr_addr_o;
    logic [31:0]       wr_data_o;
    logic              busy_o;
    logic              done_o;
    logic              error_o;
    logic [ADDR_W:0]   word_cnt_o;
    logic [31:0]       checksum_o;
    logic              core_rst_no;

    imem_loader #(.ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .len_i(len_i),
        .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i),
        .byte_ready_o(byte_ready_o), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o),
        .wr_data_o(wr_data_o), .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
        .word_cnt_o(word_cnt_o), .checksum_o(checksum_o), .core_rst_no(core_rst_no)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int ready_in_write = 0;
    int crst_bad = 0;
    logic [ADDR_W-1:0] q_addr[$];
    logic [31:0]       q_data[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Write-port and core-reset monitor, sampled mid low phase
    always begin
        @(negedge clk_i);
        #2;
        if (wr_en_o === 1'b1) begin
            q_addr.push_back(wr_addr_o);
            q_data.push_back(wr_data_o);
            if (byte_ready_o !== 1'b0) ready_in_write++;
        end
        if (core_rst_no !== (rst_ni & ~busy_o)) crst_bad++;
    end

    task automatic do_start(input int len);
        start_i = 1'b1;
        len_i   = (ADDR_W+1)'(len);
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clk_i);
        n = 0;
        byte_valid_i = 1'b1;
        byte_data_i  = b;
        while (byte_ready_o !== 1'b1 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 50) check("byte_wait", 32'(byte_ready_o), 32'h1);
        @(negedge clk_i);
        byte_valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_o !== 1'b1 && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        check("done_wait", 32'(done_o), 32'h1);
    endtask

    task automatic clear_q();
        q_addr.delete();
        q_data.delete();
    endtask

    initial begin
        repeat (2) @(negedge clk_i);
        check("rst_core_rst", 32'(core_rst_no), 32'h0);
        check("rst_wr_en", 32'(wr_en_o), 32'h0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("rst_busy", 32'(busy_o), 32'h0);
        check("rst_done", 32'(done_o), 32'h0);
        check("rst_error", 32'(error_o), 32'h0);
        check("rst_word_cnt", 32'(word_cnt_o), 32'h0);
        check("rst_checksum", checksum_o, 32'h0);
        check("rst_wr_data", wr_data_o, 32'h0);
        check("idle_ready", 32'(byte_ready_o), 32'h0);
        check("idle_core_rst", 32'(core_rst_no), 32'h1);

        // Single word
        clear_q();
        do_start(1);
        check("s1_busy", 32'(busy_o), 32'h1);
        check("s1_core_rst", 32'(core_rst_no), 32'h0);
        send_byte(8'h78, 0);
        send_byte(8'h56, 0);
        send_byte(8'h34, 0);
        send_byte(8'h12, 0);
        check("s1_wr_en", 32'(wr_en_o), 32'h1);
        check("s1_wr_addr", 32'(wr_addr_o), 32'h0);
        check("s1_wr_data", wr_data_o, 32'h12345678);
        check("s1_ready_in_write", 32'(byte_ready_o), 32'h0);
        @(negedge clk_i);
        check("s1_done", 32'(done_o), 32'h1);
        check("s1_word_cnt", 32'(word_cnt_o), 32'h1);
        check("s1_checksum", checksum_o, 32'h12345678);
        check("s1_nwrites", 32'(q_addr.size()), 32'h1);
        check("s1_core_rst_done", 32'(core_rst_no), 32'h1);
        check("s1_hold_data", wr_data_o, 32'h12345678);

        // DONE must not consume bytes
        byte_valid_i = 1'b1;
        byte_data_i  = 8'hAA;
        repeat (3) @(negedge clk_i);
        check("done_ready", 32'(byte_ready_o), 32'h0);
        check("done_word_cnt", 32'(word_cnt_o), 32'h1);
        byte_valid_i = 1'b0;

        // Three words back-to-back
        clear_q();
        do_start(3);
        check("s2_done_cleared", 32'(done_o), 32'h0);
        check("s2_cnt_cleared", 32'(word_cnt_o), 32'h0);
        send_word(32'h11223344, 0);
        send_word(32'hA5A50F0F, 0);
        send_word(32'hDEADBEEF, 0);
        wait_done();
        check("s2_nwrites", 32'(q_addr.size()), 32'h3);
        if (q_addr.size() == 3) begin
            check("s2_addr0", 32'(q_addr[0]), 32'h0);
            check("s2_addr1", 32'(q_addr[1]), 32'h1);
            check("s2_addr2", 32'(q_addr[2]), 32'h2);
            check("s2_data0", q_data[0], 32'h11223344);
            check("s2_data1", q_data[1], 32'hA5A50F0F);
            check("s2_data2", q_data[2], 32'hDEADBEEF);
        end
        check("s2_word_cnt", 32'(word_cnt_o), 32'h3);
        check("s2_checksum", checksum_o, 32'h6A2A82A4);
        check("s2_error", 32'(error_o), 32'h0);

        // Zero length and oversize length
        clear_q();
        do_start(0);
        check("s3_zero_done", 32'(done_o), 32'h1);
        check("s3_zero_error", 32'(error_o), 32'h0);
        check("s3_zero_cnt", 32'(word_cnt_o), 32'h0);
        check("s3_zero_csum", checksum_o, 32'h0);
        do_start(MEM_DEPTH + 1);
        check("s3_big_error", 32'(error_o), 32'h1);
        check("s3_big_done", 32'(done_o), 32'h1);
        check("s3_big_busy", 32'(busy_o), 32'h0);
        repeat (2) @(negedge clk_i);
        check("s3_nwrites", 32'(q_addr.size()), 32'h0);

        // Gapped bytes
        clear_q();
        do_start(2);
        check("s4_error_cleared", 32'(error_o), 32'h0);
        send_byte(8'h44, 2);
        send_byte(8'h33, 0);
        send_byte(8'h22, 3);
        send_byte(8'h11, 1);
        send_byte(8'h0F, 4);
        send_byte(8'h0F, 1);
        send_byte(8'hA5, 0);
        send_byte(8'hA5, 2);
        wait_done();
        check("s4_nwrites", 32'(q_addr.size()), 32'h2);
        if (q_addr.size() == 2) begin
            check("s4_addr1", 32'(q_addr[1]), 32'h1);
            check("s4_data0", q_data[0], 32'h11223344);
            check("s4_data1", q_data[1], 32'hA5A50F0F);
        end
        check("s4_checksum", checksum_o, 32'hB4873C4B);

        // Full-depth load aborted by reset mid-word
        clear_q();
        do_start(MEM_DEPTH);
        check("s5_depth_accepted", 32'(busy_o), 32'h1);
        check("s5_depth_no_error", 32'(error_o), 32'h0);
        send_word(32'hCAFEF00D, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        rst_ni = 1'b0;
        #1;
        check("s5_rst_busy", 32'(busy_o), 32'h0);
        check("s5_rst_core", 32'(core_rst_no), 32'h0);
        check("s5_rst_cnt", 32'(word_cnt_o), 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("s5_nwrites", 32'(q_addr.size()), 32'h1);
        clear_q();
        do_start(1);
        send_word(32'h87654321, 0);
        wait_done();
        check("s5_reload_n", 32'(q_addr.size()), 32'h1);
        if (q_addr.size() == 1) begin
            check("s5_reload_addr", 32'(q_addr[0]), 32'h0);
            check("s5_reload_data", q_data[0], 32'h87654321);
        end

        // start_i during RECV is ignored
        clear_q();
        do_start(2);
        send_byte(8'hEF, 0);
        send_byte(8'hBE, 0);
        start_i = 1'b1;
        len_i   = (ADDR_W+1)'(1);
        @(negedge clk_i);
        start_i = 1'b0;
        send_byte(8'hAD, 0);
        send_byte(8'hDE, 0);
        send_word(32'h0BADF00D, 0);
        wait_done();
        check("s6_word_cnt", 32'(word_cnt_o), 32'h2);
        check("s6_nwrites", 32'(q_addr.size()), 32'h2);
        check("s6_checksum", checksum_o, 32'hD5004EE2);

        check("ready_in_write", 32'(ready_in_write), 32'h0);
        check("core_rst_eqn", 32'(crst_bad), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
